// File: rtl/cordic_sincos_gen.sv
// cordic_sincos_gen: regenerates raw cx/cy encoder samples from a first-quadrant
// angle plus quadrant code using an iterative rotation-mode CORDIC, quadrant unfold,
// and per-axis amplitude/DC scaling with saturation.
// Optional build macro SINCOS_ROUND_EN: round half up in the scaling stage
// (default build floors the scaled product).
module cordic_sincos_gen #(
  parameter int ITER   = 16,
  parameter int CX_DC  = 17685,
  parameter int CY_DC  = 16800,
  parameter int CX_AMP = 3362,
  parameter int CY_AMP = 3193
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] theta_in,
  input  logic [1:0]  quad_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] cx_out,
  output logic [15:0] cy_out
);

  localparam int unsigned TH_W      = 17;
  localparam int unsigned XY_W      = 18;
  localparam int unsigned P_W       = 34;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned I_W       = 4;
  localparam int unsigned FRAC_W    = 14;
  localparam int          THETA_MAX = 25736;
  localparam int          X_INIT    = 9949;
  localparam int          OUT_MAX   = 32767;
  localparam int          OUT_MIN   = -32768;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROT,
    S_UNFOLD,
    S_SCALE,
    S_HOLD
  } state_t;

  state_t                    state_q;
  logic signed [XY_W-1:0]    x_q, y_q;
  logic signed [TH_W-1:0]    z_q;
  logic        [I_W-1:0]     i_q;
  logic        [1:0]         quad_q;
  logic signed [XY_W-1:0]    cu_q, su_q;

  logic signed [TH_W-1:0]    theta_s;
  logic signed [TH_W-1:0]    theta_d;
  logic                      dir;
  logic signed [XY_W-1:0]    x_sh, y_sh;
  logic signed [TH_W-1:0]    atan_v;
  logic signed [XY_W-1:0]    x_d, y_d;
  logic signed [TH_W-1:0]    z_d;
  logic signed [XY_W-1:0]    cu_d, su_d;
  logic signed [P_W-1:0]     prod_cx, prod_cy;
  logic signed [P_W-1:0]     sum_cx, sum_cy;
  logic        [OUT_W-1:0]   cx_d, cy_d;

  // arctangent of 2^-idx in Q14 radians
  function automatic logic signed [TH_W-1:0] atan_lut(input logic [I_W-1:0] idx);
    case (idx)
      4'd0:    atan_lut = TH_W'(12868);
      4'd1:    atan_lut = TH_W'(7596);
      4'd2:    atan_lut = TH_W'(4014);
      4'd3:    atan_lut = TH_W'(2037);
      4'd4:    atan_lut = TH_W'(1023);
      4'd5:    atan_lut = TH_W'(512);
      4'd6:    atan_lut = TH_W'(256);
      4'd7:    atan_lut = TH_W'(128);
      4'd8:    atan_lut = TH_W'(64);
      4'd9:    atan_lut = TH_W'(32);
      4'd10:   atan_lut = TH_W'(16);
      4'd11:   atan_lut = TH_W'(8);
      4'd12:   atan_lut = TH_W'(4);
      4'd13:   atan_lut = TH_W'(2);
      4'd14:   atan_lut = TH_W'(1);
      default: atan_lut = TH_W'(0);
    endcase
  endfunction

  // clip a wide signed sum into the 16-bit output range
  function automatic logic [OUT_W-1:0] sat16(input logic signed [P_W-1:0] v);
    if (v > P_W'(OUT_MAX))      sat16 = OUT_W'(OUT_MAX);
    else if (v < P_W'(OUT_MIN)) sat16 = OUT_W'(OUT_MIN);
    else                        sat16 = v[OUT_W-1:0];
  endfunction

  assign in_ready = (state_q == S_IDLE);

  // clamp incoming angle to the legal first-quadrant range
  always_comb begin
    theta_s = $signed(theta_in);
    theta_d = theta_s;
    if (theta_s < TH_W'(0))              theta_d = TH_W'(0);
    else if (theta_s > TH_W'(THETA_MAX)) theta_d = TH_W'(THETA_MAX);
  end

  // one CORDIC micro-rotation driven toward z = 0
  always_comb begin
    dir    = ~z_q[TH_W-1];
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_v = atan_lut(i_q);
    x_d    = dir ? (x_q - y_sh)   : (x_q + y_sh);
    y_d    = dir ? (y_q + x_sh)   : (y_q - x_sh);
    z_d    = dir ? (z_q - atan_v) : (z_q + atan_v);
  end

  // map first-quadrant cos/sin onto the requested quadrant
  always_comb begin
    cu_d = x_q;
    su_d = y_q;
    case (quad_q)
      2'd1:    begin cu_d = -y_q; su_d = x_q;  end
      2'd2:    begin cu_d = -x_q; su_d = -y_q; end
      2'd3:    begin cu_d = y_q;  su_d = -x_q; end
      default: begin cu_d = x_q;  su_d = y_q;  end
    endcase
  end

  // amplitude scaling, DC offset and saturation
  always_comb begin
    prod_cx = P_W'(cu_q) * P_W'(CX_AMP);
    prod_cy = P_W'(su_q) * P_W'(CY_AMP);
`ifdef SINCOS_ROUND_EN
    prod_cx = prod_cx + P_W'(2 ** (FRAC_W - 1));
    prod_cy = prod_cy + P_W'(2 ** (FRAC_W - 1));
`endif
    sum_cx = (prod_cx >>> FRAC_W) + P_W'(CX_DC);
    sum_cy = (prod_cy >>> FRAC_W) + P_W'(CY_DC);
    cx_d   = sat16(sum_cx);
    cy_d   = sat16(sum_cy);
  end

  // control FSM with datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      i_q       <= '0;
      quad_q    <= '0;
      cu_q      <= '0;
      su_q      <= '0;
      out_valid <= 1'b0;
      cx_out    <= OUT_W'(CX_DC);
      cy_out    <= OUT_W'(CY_DC);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_q     <= XY_W'(X_INIT);
            y_q     <= '0;
            z_q     <= theta_d;
            quad_q  <= quad_in;
            i_q     <= '0;
            state_q <= S_ROT;
          end
        end
        S_ROT: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          i_q <= i_q + I_W'(1);
          if (i_q == I_W'(ITER - 1)) state_q <= S_UNFOLD;
        end
        S_UNFOLD: begin
          cu_q    <= cu_d;
          su_q    <= su_d;
          state_q <= S_SCALE;
        end
        S_SCALE: begin
          cx_out    <= cx_d;
          cy_out    <= cy_d;
          out_valid <= 1'b1;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos_gen.sv
// Directed bench for cordic_sincos_gen: table of angle/quadrant vectors with
// hand-computed cx/cy targets, plus backpressure, mid-run reset and saturation cases.
module tb_cordic_sincos_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] theta_in;
  logic [1:0]  quad_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cx_out;
  logic [15:0] cy_out;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] cx_out2;
  logic [15:0] cy_out2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_sincos_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .theta_in  (theta_in),
    .quad_in   (quad_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cx_out    (cx_out),
    .cy_out    (cy_out)
  );

  // large cx amplitude forces positive saturation
  cordic_sincos_gen #(.CX_AMP(20000)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .theta_in  (theta_in),
    .quad_in   (quad_in),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .cx_out    (cx_out2),
    .cy_out    (cy_out2)
  );

  typedef struct {
    int theta;
    int quad;
    int cx;
    int cy;
    int tol;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // present one request at a negedge; returns just after the accepting edge's negedge
  task automatic send(input int theta, input int quad);
    chk("in_ready_before_send", int'(in_ready), 1, 0);
    in_valid = 1'b1;
    theta_in = 17'(theta);
    quad_in  = 2'(quad);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // count edges after the accepting edge until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // hand the result off and confirm the return to idle
  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, int'(out_valid), 0, 0);
    chk({tag, "_in_ready_back"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cx_hold;
    int cy_hold;
    bit stable;
    bit busy_ok;

    vecs[0] = '{theta: 0,     quad: 0, cx: 21047, cy: 16800, tol: 2};
    vecs[1] = '{theta: 0,     quad: 1, cx: 17685, cy: 19993, tol: 2};
    vecs[2] = '{theta: 0,     quad: 2, cx: 14323, cy: 16800, tol: 2};
    vecs[3] = '{theta: 0,     quad: 3, cx: 17685, cy: 13607, tol: 2};
    vecs[4] = '{theta: 12868, quad: 0, cx: 20062, cy: 19058, tol: 3};
    vecs[5] = '{theta: 30000, quad: 0, cx: 17685, cy: 19993, tol: 2};
    vecs[6] = '{theta: -5,    quad: 0, cx: 21047, cy: 16800, tol: 2};
    vecs[7] = '{theta: 25736, quad: 2, cx: 17685, cy: 13607, tol: 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    theta_in  = '0;
    quad_in   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1, 0);
    chk("reset_out_valid", int'(out_valid), 0, 0);
    chk("reset_cx", int'($signed(cx_out)), 17685, 0);
    chk("reset_cy", int'($signed(cy_out)), 16800, 0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven transactions
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].theta, vecs[i].quad);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), lat, 18, 0);
      chk($sformatf("vec%0d_cx", i), int'($signed(cx_out)), vecs[i].cx, vecs[i].tol);
      chk($sformatf("vec%0d_cy", i), int'($signed(cy_out)), vecs[i].cy, vecs[i].tol);
      if (i == 0) begin
        chk("sat_out_valid", int'(out_valid2), 1, 0);
        chk("sat_cx", int'($signed(cx_out2)), 32767, 0);
        chk("sat_cy", int'($signed(cy_out2)), 16800, 2);
      end
      handoff($sformatf("vec%0d", i));
    end

    // backpressure: hold 20 cycles, busy in_valid must be ignored
    send(12868, 0);
    wait_out(lat);
    chk("bp_latency", lat, 18, 0);
    cx_hold = int'($signed(cx_out));
    cy_hold = int'($signed(cy_out));
    stable  = 1'b1;
    busy_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        theta_in = 17'(0);
        quad_in  = 2'd2;
      end
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || int'($signed(cx_out)) != cx_hold || int'($signed(cy_out)) != cy_hold)
        stable = 1'b0;
      if (in_ready) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_outputs_stable", int'(stable), 1, 0);
    chk("bp_in_ready_low", int'(busy_ok), 1, 0);
    chk("bp_cx", cx_hold, 20062, 3);
    handoff("bp");
    chk("bp_cx_kept", int'($signed(cx_out)), cx_hold, 0);
    lat = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("bp_ignored_request", lat, 0, 0);

    // reset during ROT iteration 5 aborts the transaction
    send(0, 0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_cx", int'($signed(cx_out)), 17685, 0);
    chk("midrst_cy", int'($signed(cy_out)), 16800, 0);
    send(0, 3);
    wait_out(lat);
    chk("postrst_latency", lat, 18, 0);
    chk("postrst_cx", int'($signed(cx_out)), 17685, 2);
    chk("postrst_cy", int'($signed(cy_out)), 13607, 2);
    handoff("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
